// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control FSM: opcodes, state codes,
// datapath mux encodings and the per-state strobe bundle.
package mips_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ST_W  = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 4'd1;
    localparam logic [ST_W-1:0] ST_DECODE = 4'd2;
    localparam logic [ST_W-1:0] ST_MEMADR = 4'd3;
    localparam logic [ST_W-1:0] ST_MEMRD  = 4'd4;
    localparam logic [ST_W-1:0] ST_MEMWB  = 4'd5;
    localparam logic [ST_W-1:0] ST_MEMWR  = 4'd6;
    localparam logic [ST_W-1:0] ST_EXEC   = 4'd7;
    localparam logic [ST_W-1:0] ST_RWB    = 4'd8;
    localparam logic [ST_W-1:0] ST_BRANCH = 4'd9;
    localparam logic [ST_W-1:0] ST_JUMP   = 4'd10;
    localparam logic [ST_W-1:0] ST_ADDIEX = 4'd11;
    localparam logic [ST_W-1:0] ST_ADDIWB = 4'd12;
    localparam logic [ST_W-1:0] ST_TRAP   = 4'd13;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle: instruction opcode and memory handshake in,
// per-state datapath strobes and the retired-instruction count out.
interface multicycle_control_if #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 32
);
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_source;
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore strobe decoder: maps the control state to datapath strobes; fetch_done
// only qualifies the FETCH-state IR/PC load.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [ST_W-1:0] state,
    input  logic            fetch_done,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = fetch_done;
                ctrl.pc_write  = fetch_done;
            end
            // branch target computed speculatively while the opcode resolves
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: state register, opcode-driven sequencing,
// memory wait handling and retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W    = 2,
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             retire;
    logic             mem_ok;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl;

    // without wait states every memory access completes in its first cycle
    assign mem_ok = (MEM_WAIT_EN == 0) ? 1'b1 : bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // unknown or unsupported opcodes fall through to TRAP via the default arm
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH:  if (mem_ok) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = ST_MEMADR;
                    OP_RTYPE:     state_nxt = ST_EXEC;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_ADDI:      state_nxt = ST_ADDIEX;
                    OP_J:         state_nxt = ST_JUMP;
                    default:      state_nxt = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_nxt = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ok) state_nxt = ST_MEMWB;
            ST_MEMWR: begin
                if (mem_ok) begin
                    state_nxt = ST_FETCH;
                    retire    = 1'b1;
                end
            end
            ST_EXEC:   state_nxt = ST_RWB;
            ST_ADDIEX: state_nxt = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            ST_TRAP:   state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state      (state),
        .fetch_done (mem_ok),
        .ctrl       (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ALU_OP_W'(ctrl.alu_op);
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal       = ctrl.illegal;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence, checking state, strobes and the retired count every cycle.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multicycle_control_if #(.ALU_OP_W(2), .CNT_W(32)) bus ();

    multicycle_control #(.ALU_OP_W(2), .MEM_WAIT_EN(1), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected strobes per state, written straight from the state table
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy);
        ctrl_t e;
        e = '0;
        case (st)
            ST_FETCH:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                             e.ir_write = rdy;  e.pc_write  = rdy; end
            ST_DECODE: e.alu_src_b = 2'b11;
            ST_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            ST_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            ST_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
            ST_EXEC:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            ST_RWB:    begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            ST_BRANCH: begin e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                             e.pc_write_cond = 1'b1; e.pc_source = 2'b01; end
            ST_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_ADDIWB: e.reg_write = 1'b1;
            ST_JUMP:   begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
            ST_TRAP:   e.illegal = 1'b1;
            default:   e = '0;
        endcase
        return e;
    endfunction

    function automatic ctrl_t obs_ctrl();
        ctrl_t o;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.iord          = bus.iord;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.pc_source     = bus.pc_source;
        o.illegal       = bus.illegal;
        return o;
    endfunction

    task automatic check_outs(input string tag, input logic [3:0] st, input logic rdy);
        ctrl_t o;
        ctrl_t e;
        o = obs_ctrl();
        e = exp_ctrl(st, rdy);
        total++;
        assert (dut.state === st) else begin
            bad++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, dut.state, st);
        end
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s strobes obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic check_ret(input string tag, input logic [31:0] exp);
        total++;
        assert (bus.retired === exp) else begin
            bad++;
            $error("FAIL %s retired obs=%0d exp=%0d", tag, bus.retired, exp);
        end
    endtask

    // one clock: drive inputs, check current state/strobes, advance past the edge
    task automatic cyc(input string tag, input logic [3:0] st, input logic rdy,
                       input logic [5:0] opc);
        bus.mem_ready = rdy;
        bus.opcode    = opc;
        #1;
        check_outs(tag, st, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_RTYPE;
        @(posedge clk);
        #1;
        cyc("rst.hold", ST_IDLE, 1'b1, OP_LW);
        check_ret("rst", 32'd0);
        rst_n = 1'b1;

        // lw with zero wait states
        cyc("lw.idle",   ST_IDLE,   1'b1, OP_LW);
        cyc("lw.fetch",  ST_FETCH,  1'b1, OP_LW);
        cyc("lw.decode", ST_DECODE, 1'b1, OP_LW);
        cyc("lw.memadr", ST_MEMADR, 1'b1, OP_LW);
        cyc("lw.memrd",  ST_MEMRD,  1'b1, OP_LW);
        cyc("lw.memwb",  ST_MEMWB,  1'b1, OP_LW);
        check_ret("lw", 32'd1);

        // sw with three wait cycles in MEMWR
        cyc("sw.fetch",  ST_FETCH,  1'b1, OP_SW);
        cyc("sw.decode", ST_DECODE, 1'b1, OP_SW);
        cyc("sw.memadr", ST_MEMADR, 1'b1, OP_SW);
        cyc("sw.wait0",  ST_MEMWR,  1'b0, OP_SW);
        check_ret("sw.hold", 32'd1);
        cyc("sw.wait1",  ST_MEMWR,  1'b0, OP_SW);
        cyc("sw.wait2",  ST_MEMWR,  1'b0, OP_SW);
        cyc("sw.done",   ST_MEMWR,  1'b1, OP_SW);
        check_ret("sw", 32'd2);

        // R-type with two fetch wait cycles
        cyc("fw.wait0",  ST_FETCH,  1'b0, OP_RTYPE);
        cyc("fw.wait1",  ST_FETCH,  1'b0, OP_RTYPE);
        cyc("fw.done",   ST_FETCH,  1'b1, OP_RTYPE);
        cyc("fw.decode", ST_DECODE, 1'b1, OP_RTYPE);
        cyc("fw.exec",   ST_EXEC,   1'b1, OP_RTYPE);
        cyc("fw.rwb",    ST_RWB,    1'b1, OP_RTYPE);
        check_ret("r1", 32'd3);

        // illegal opcode: single trap cycle, no retire
        cyc("ill.fetch",  ST_FETCH,  1'b1, 6'b111111);
        cyc("ill.decode", ST_DECODE, 1'b1, 6'b111111);
        cyc("ill.trap",   ST_TRAP,   1'b1, 6'b111111);
        check_ret("ill", 32'd3);

        // beq, j, addi, R-type back to back
        cyc("beq.fetch",  ST_FETCH,  1'b1, OP_BEQ);
        cyc("beq.decode", ST_DECODE, 1'b1, OP_BEQ);
        cyc("beq.branch", ST_BRANCH, 1'b1, OP_BEQ);
        check_ret("beq", 32'd4);
        cyc("j.fetch",    ST_FETCH,  1'b1, OP_J);
        cyc("j.decode",   ST_DECODE, 1'b1, OP_J);
        cyc("j.jump",     ST_JUMP,   1'b1, OP_J);
        check_ret("j", 32'd5);
        cyc("ai.fetch",   ST_FETCH,  1'b1, OP_ADDI);
        cyc("ai.decode",  ST_DECODE, 1'b1, OP_ADDI);
        cyc("ai.ex",      ST_ADDIEX, 1'b1, OP_ADDI);
        cyc("ai.wb",      ST_ADDIWB, 1'b1, OP_ADDI);
        check_ret("addi", 32'd6);
        cyc("r2.fetch",   ST_FETCH,  1'b1, OP_RTYPE);
        cyc("r2.decode",  ST_DECODE, 1'b1, OP_RTYPE);
        cyc("r2.exec",    ST_EXEC,   1'b1, OP_RTYPE);
        cyc("r2.rwb",     ST_RWB,    1'b1, OP_RTYPE);
        check_ret("r2", 32'd7);

        // reset asserted mid-MEMRD
        cyc("mr.fetch",  ST_FETCH,  1'b1, OP_LW);
        cyc("mr.decode", ST_DECODE, 1'b1, OP_LW);
        cyc("mr.memadr", ST_MEMADR, 1'b1, OP_LW);
        bus.mem_ready = 1'b0;
        #1;
        check_outs("mr.memrd", ST_MEMRD, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("mr.reset", ST_IDLE, 1'b0);
        check_ret("mr.reset", 32'd0);
        rst_n = 1'b1;
        cyc("mr.idle",   ST_IDLE,   1'b1, OP_LW);
        cyc("mr.refetch", ST_FETCH, 1'b1, OP_LW);
        check_ret("mr.after", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
